// File: rtl/control_pkg.sv
// ----------------------------------------------------------------------------
// control_pkg
//
// Shared definitions for the SPI-to-coax command decoder:
//   - command byte codes (STATUS, TX, RX)
//   - decoder state enum
//   - bit positions of the flags carried in the RX high byte
//   - helpers that decode a command byte and assemble the RX high byte and the
//     STATUS byte
//
// Configuration macro: CONTROL_STATUS_CMD_EN
//   defined   : CMD_STATUS decodes to the STATUS state
//   undefined : CMD_STATUS is treated like any unknown byte (IGNORE)
// ----------------------------------------------------------------------------
package control_pkg;

    // Command codes: the first byte seen after chip-select falls.
    localparam logic [7:0] CMD_STATUS = 8'h01;
    localparam logic [7:0] CMD_TX     = 8'h04;
    localparam logic [7:0] CMD_RX     = 8'h05;

    // Flag positions inside the RX high byte {empty, error, 4'b0, data[9:8]}.
    localparam int RX_FLAG_EMPTY_BIT = 7;
    localparam int RX_FLAG_ERROR_BIT = 6;

    // Cycles from the RX_LO strobe to the cycle in which the new FIFO head is
    // sampled. The pop is issued one cycle after the strobe and the head is
    // given two more cycles to settle.
    localparam logic [1:0] RX_RELOAD_DELAY = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TX_HI,
        ST_TX_LO,
        ST_RX_HI,
        ST_RX_LO,
        ST_STATUS,
        ST_IGNORE
    } state_e;

    // Map a command byte to the state that handles the rest of the transfer.
    function automatic state_e decode_cmd(input logic [7:0] cmd);
        state_e next;
        case (cmd)
            CMD_TX:     next = ST_TX_HI;
            CMD_RX:     next = ST_RX_HI;
`ifdef CONTROL_STATUS_CMD_EN
            CMD_STATUS: next = ST_STATUS;
`endif
            default:    next = ST_IGNORE;
        endcase
        return next;
    endfunction

    // High byte returned for each RX word: FIFO flags plus data bits [9:8].
    function automatic logic [7:0] rx_high_byte(input logic       empty,
                                                input logic       error,
                                                input logic [1:0] data_hi);
        logic [7:0] b;
        b                    = 8'h00;
        b[RX_FLAG_EMPTY_BIT] = empty;
        b[RX_FLAG_ERROR_BIT] = error;
        b[1:0]               = data_hi;
        return b;
    endfunction

    // Live status byte shown while a STATUS command is open.
    function automatic logic [7:0] status_byte(input logic empty,
                                               input logic error,
                                               input logic active);
        return {5'b0_0000, empty, error, active};
    endfunction

endpackage

// File: rtl/control.sv
// ----------------------------------------------------------------------------
// control
//
// Command decoder between the SPI slave front end and the coax TX/RX
// datapaths. While spi_cs is low, the first received byte selects a command:
//   0x04 TX     : following byte pairs form 10-bit words pushed via tx_load
//   0x05 RX     : FIFO words are streamed back as {flags, data[9:8]}, data[7:0]
//                 and the FIFO is popped after each word
//   0x01 STATUS : spi_tx_data mirrors {rx_empty, rx_error, rx_active}
//                 (only when CONTROL_STATUS_CMD_EN is defined)
//   other       : ignored until spi_cs rises
// spi_cs high returns to IDLE, drops any partial TX word and clears
// spi_tx_data.
//
// Ports:
//   clk            system clock, rising edge
//   reset          synchronous active-low reset
//   spi_cs         SPI chip-select, active low
//   spi_rx_data    byte from the SPI master, valid with spi_rx_strobe
//   spi_rx_strobe  one-cycle pulse per received byte
//   spi_tx_data    byte shifted out on the next SPI transfer
//   rx_active      receiver decoding a frame
//   rx_error       receiver error flag
//   rx_data        head word of the receive FIFO
//   rx_empty       receive FIFO empty
//   rx_read        one-cycle FIFO pop
//   tx_data        word for the transmitter, valid with tx_load
//   tx_load        one-cycle push strobe to the transmitter
//
// Configuration macro: CONTROL_STATUS_CMD_EN enables the STATUS command.
// ----------------------------------------------------------------------------
module control
    import control_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       spi_cs,
    input  logic [7:0] spi_rx_data,
    input  logic       spi_rx_strobe,
    output logic [7:0] spi_tx_data,
    input  logic       rx_active,
    input  logic       rx_error,
    input  logic [9:0] rx_data,
    input  logic       rx_empty,
    output logic       rx_read,
    output logic [9:0] tx_data,
    output logic       tx_load
);

    state_e     state_q,       state_d;
    logic [7:0] spi_tx_data_q, spi_tx_data_d;
    logic [9:0] tx_data_q,     tx_data_d;
    logic       tx_load_q,     tx_load_d;
    logic       rx_read_q,     rx_read_d;
    logic [1:0] tx_hi_q,       tx_hi_d;       // latched word bits [9:8]
    logic [1:0] reload_cnt_q,  reload_cnt_d;  // pending RX high-byte reload

    // A byte counts only while chip-select is low; CS high wins over a strobe.
    logic byte_valid;
    assign byte_valid = spi_rx_strobe && !spi_cs;

`ifndef CONTROL_STATUS_CMD_EN
    // rx_active only feeds the STATUS byte.
    logic rx_active_unused;
    assign rx_active_unused = rx_active;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // values from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: every variable assigned in always_comb gets a default first so no
    // path leaves it unassigned, which would infer a latch.
    always_comb begin
        state_d = state_q;
        if (spi_cs) begin
            state_d = ST_IDLE;
        end else if (byte_valid) begin
            case (state_q)
                ST_IDLE:  state_d = decode_cmd(spi_rx_data);
                ST_TX_HI: state_d = ST_TX_LO;
                ST_TX_LO: state_d = ST_TX_HI;
                ST_RX_HI: state_d = ST_RX_LO;
                ST_RX_LO: state_d = ST_RX_HI;
                default:  state_d = state_q;   // STATUS / IGNORE absorb bytes
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output / datapath next values
    // ------------------------------------------------------------------
    always_comb begin
        spi_tx_data_d = spi_tx_data_q;
        tx_data_d     = tx_data_q;
        tx_load_d     = 1'b0;
        rx_read_d     = 1'b0;
        tx_hi_d       = tx_hi_q;
        reload_cnt_d  = reload_cnt_q;

        if (spi_cs) begin
            spi_tx_data_d = 8'h00;
            tx_hi_d       = 2'b00;
            reload_cnt_d  = 2'd0;
        end else begin
            // Delayed reload of the RX high byte after a pop, so the FIFO
            // head has moved to the next word before it is sampled.
            if (reload_cnt_q != 2'd0) begin
                reload_cnt_d = reload_cnt_q - 2'd1;
                if (reload_cnt_q == 2'd1) begin
                    spi_tx_data_d = rx_high_byte(rx_empty, rx_error, rx_data[9:8]);
                end
            end

            case (state_q)
                ST_IDLE: begin
                    if (byte_valid) begin
                        if (decode_cmd(spi_rx_data) == ST_RX_HI) begin
                            spi_tx_data_d = rx_high_byte(rx_empty, rx_error,
                                                         rx_data[9:8]);
                        end
`ifdef CONTROL_STATUS_CMD_EN
                        if (decode_cmd(spi_rx_data) == ST_STATUS) begin
                            spi_tx_data_d = status_byte(rx_empty, rx_error,
                                                        rx_active);
                        end
`endif
                    end
                end
                ST_TX_HI: begin
                    if (byte_valid) begin
                        tx_hi_d = spi_rx_data[1:0];
                    end
                end
                ST_TX_LO: begin
                    if (byte_valid) begin
                        tx_data_d = {tx_hi_q, spi_rx_data};
                        tx_load_d = 1'b1;
                    end
                end
                ST_RX_HI: begin
                    if (byte_valid) begin
                        spi_tx_data_d = rx_data[7:0];
                        reload_cnt_d  = 2'd0;
                    end
                end
                ST_RX_LO: begin
                    if (byte_valid) begin
                        // An empty FIFO is re-read but never popped.
                        rx_read_d    = !rx_empty;
                        reload_cnt_d = RX_RELOAD_DELAY;
                    end
                end
                ST_STATUS: begin
`ifdef CONTROL_STATUS_CMD_EN
                    spi_tx_data_d = status_byte(rx_empty, rx_error, rx_active);
`endif
                end
                default: begin
                    // IGNORE: nothing changes until CS rises.
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath / output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            spi_tx_data_q <= 8'h00;
            tx_data_q     <= 10'd0;
            tx_load_q     <= 1'b0;
            rx_read_q     <= 1'b0;
            tx_hi_q       <= 2'b00;
            reload_cnt_q  <= 2'd0;
        end else begin
            spi_tx_data_q <= spi_tx_data_d;
            tx_data_q     <= tx_data_d;
            tx_load_q     <= tx_load_d;
            rx_read_q     <= rx_read_d;
            tx_hi_q       <= tx_hi_d;
            reload_cnt_q  <= reload_cnt_d;
        end
    end

    assign spi_tx_data = spi_tx_data_q;
    assign tx_data     = tx_data_q;
    assign tx_load     = tx_load_q;
    assign rx_read     = rx_read_q;

endmodule

// File: tb/tb_control.sv
// ----------------------------------------------------------------------------
// tb_control
//
// Directed self-checking bench for control. Expected values are written out
// by hand from the command protocol. The STATUS expectations follow
// CONTROL_STATUS_CMD_EN so the bench fits either build.
// ----------------------------------------------------------------------------
module tb_control;
    import control_pkg::*;

    logic       clk;
    logic       reset;
    logic       spi_cs;
    logic [7:0] spi_rx_data;
    logic       spi_rx_strobe;
    logic [7:0] spi_tx_data;
    logic       rx_active;
    logic       rx_error;
    logic [9:0] rx_data;
    logic       rx_empty;
    logic       rx_read;
    logic [9:0] tx_data;
    logic       tx_load;

    int vectors;
    int miscompares;

    // Cycles in which each strobe was seen high, plus the word seen with the
    // most recent tx_load.
    int         tx_load_cnt;
    int         rx_read_cnt;
    logic [9:0] tx_word_seen;

    control dut (
        .clk          (clk),
        .reset        (reset),
        .spi_cs       (spi_cs),
        .spi_rx_data  (spi_rx_data),
        .spi_rx_strobe(spi_rx_strobe),
        .spi_tx_data  (spi_tx_data),
        .rx_active    (rx_active),
        .rx_error     (rx_error),
        .rx_data      (rx_data),
        .rx_empty     (rx_empty),
        .rx_read      (rx_read),
        .tx_data      (tx_data),
        .tx_load      (tx_load)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tx_load === 1'b1) begin
            tx_load_cnt  = tx_load_cnt + 1;
            tx_word_seen = tx_data;
        end
        if (rx_read === 1'b1) begin
            rx_read_cnt = rx_read_cnt + 1;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One strobed byte followed by a 6-cycle gap. With drain set, the FIFO
    // model turns empty (head 0) right after the strobe cycle.
    task automatic send_byte(input logic [7:0] b, input bit drain);
        @(posedge clk);
        #1;
        spi_rx_data   = b;
        spi_rx_strobe = 1'b1;
        @(posedge clk);
        #1;
        spi_rx_strobe = 1'b0;
        if (drain) begin
            rx_empty = 1'b1;
            rx_data  = 10'd0;
        end
        tick(5);
    endtask

    task automatic cs_high();
        spi_cs = 1'b1;
        tick(2);
    endtask

    task automatic clear_counts();
        tx_load_cnt = 0;
        rx_read_cnt = 0;
    endtask

    task automatic test_reset();
        // Strobe a TX command during reset: reset must win.
        spi_cs        = 1'b0;
        spi_rx_data   = CMD_TX;
        spi_rx_strobe = 1'b1;
        reset         = 1'b0;
        tick(1);
        spi_rx_strobe = 1'b0;
        reset         = 1'b1;
        #1;
        vectors++;
        if (dut.state_q !== ST_IDLE) begin
            miscompares++;
            $display("FAIL reset_state: got %0d expected %0d", dut.state_q, ST_IDLE);
        end
        vectors++;
        if ({spi_tx_data, tx_data, tx_load, rx_read} !== 20'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: spi_tx_data=%h tx_data=%h tx_load=%b rx_read=%b expected all 0",
                     spi_tx_data, tx_data, tx_load, rx_read);
        end
        cs_high();
    endtask

    task automatic test_tx();
        clear_counts();
        spi_cs = 1'b0;
        send_byte(CMD_TX, 1'b0);
        send_byte(8'h03, 1'b0);
        vectors++;
        if (tx_load_cnt !== 0) begin
            miscompares++;
            $display("FAIL tx_early_load: got %0d pulses expected 0", tx_load_cnt);
        end
        send_byte(8'hFF, 1'b0);
        vectors++;
        if (tx_load_cnt !== 1) begin
            miscompares++;
            $display("FAIL tx_load_pulse: got %0d cycles expected 1", tx_load_cnt);
        end
        vectors++;
        if (tx_word_seen !== 10'h3FF) begin
            miscompares++;
            $display("FAIL tx_word: got %h expected 3ff", tx_word_seen);
        end
        cs_high();
        vectors++;
        if (dut.state_q !== ST_IDLE) begin
            miscompares++;
            $display("FAIL tx_cs_idle: got %0d expected %0d", dut.state_q, ST_IDLE);
        end
    endtask

    task automatic test_rx();
        rx_data  = 10'h3FF;
        rx_empty = 1'b0;
        rx_error = 1'b0;
        clear_counts();
        spi_cs = 1'b0;
        send_byte(CMD_RX, 1'b0);
        vectors++;
        if (spi_tx_data !== 8'h03) begin
            miscompares++;
            $display("FAIL rx_high: got %h expected 03", spi_tx_data);
        end
        send_byte(8'h00, 1'b0);
        vectors++;
        if (spi_tx_data !== 8'hFF) begin
            miscompares++;
            $display("FAIL rx_low: got %h expected ff", spi_tx_data);
        end
        send_byte(8'h00, 1'b1);
        vectors++;
        if (rx_read_cnt !== 1) begin
            miscompares++;
            $display("FAIL rx_pop: got %0d cycles expected 1", rx_read_cnt);
        end
        vectors++;
        if (spi_tx_data !== 8'h80) begin
            miscompares++;
            $display("FAIL rx_empty_high: got %h expected 80", spi_tx_data);
        end
    endtask

    task automatic test_rx_empty_pairs();
        int bad_lo;
        int bad_hi;
        bad_lo = 0;
        bad_hi = 0;
        clear_counts();
        for (int i = 0; i < 8; i++) begin
            send_byte(8'hA5, 1'b0);
            if (spi_tx_data !== 8'h00) bad_lo++;
            send_byte(8'h5A, 1'b0);
            if (spi_tx_data !== 8'h80) bad_hi++;
        end
        vectors++;
        if (bad_lo !== 0) begin
            miscompares++;
            $display("FAIL rx_empty_low: %0d of 8 pairs wrong, expected 0 wrong", bad_lo);
        end
        vectors++;
        if (bad_hi !== 0) begin
            miscompares++;
            $display("FAIL rx_empty_reload: %0d of 8 pairs wrong, expected 0 wrong", bad_hi);
        end
        vectors++;
        if (rx_read_cnt !== 0) begin
            miscompares++;
            $display("FAIL rx_empty_nopop: got %0d pops expected 0", rx_read_cnt);
        end
        cs_high();
        vectors++;
        if (spi_tx_data !== 8'h00) begin
            miscompares++;
            $display("FAIL rx_cs_clear: got %h expected 00", spi_tx_data);
        end
    endtask

    task automatic test_cs_wins();
        rx_data  = 10'h3FF;
        rx_empty = 1'b0;
        // spi_cs stays high while the command byte strobes.
        send_byte(CMD_RX, 1'b0);
        vectors++;
        if (dut.state_q !== ST_IDLE || spi_tx_data !== 8'h00) begin
            miscompares++;
            $display("FAIL cs_wins: state=%0d spi_tx_data=%h expected state %0d data 00",
                     dut.state_q, spi_tx_data, ST_IDLE);
        end
    endtask

    task automatic test_tx_abort();
        clear_counts();
        spi_cs = 1'b0;
        send_byte(CMD_TX, 1'b0);
        send_byte(8'h01, 1'b0);
        cs_high();
        vectors++;
        if (tx_load_cnt !== 0) begin
            miscompares++;
            $display("FAIL tx_abort_load: got %0d pulses expected 0", tx_load_cnt);
        end
        spi_cs = 1'b0;
        send_byte(CMD_TX, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h5A, 1'b0);
        vectors++;
        if (tx_load_cnt !== 1 || tx_word_seen !== 10'h25A) begin
            miscompares++;
            $display("FAIL tx_after_abort: got %0d pulses word %h expected 1 pulse word 25a",
                     tx_load_cnt, tx_word_seen);
        end
        cs_high();
    endtask

    task automatic test_status();
        logic [7:0] exp_first;
        logic [7:0] exp_live;
`ifdef CONTROL_STATUS_CMD_EN
        exp_first = 8'h03;
        exp_live  = 8'h07;
`else
        exp_first = 8'h00;
        exp_live  = 8'h00;
`endif
        rx_active = 1'b1;
        rx_error  = 1'b1;
        rx_empty  = 1'b0;
        spi_cs    = 1'b0;
        send_byte(CMD_STATUS, 1'b0);
        vectors++;
        if (spi_tx_data !== exp_first) begin
            miscompares++;
            $display("FAIL status_byte: got %h expected %h", spi_tx_data, exp_first);
        end
        rx_empty = 1'b1;
        send_byte(CMD_TX, 1'b0);
        vectors++;
        if (spi_tx_data !== exp_live) begin
            miscompares++;
            $display("FAIL status_refresh: got %h expected %h", spi_tx_data, exp_live);
        end
        cs_high();
        rx_active = 1'b0;
        rx_error  = 1'b0;
    endtask

    task automatic test_ignore();
        rx_data  = 10'h155;
        rx_empty = 1'b0;
        clear_counts();
        spi_cs = 1'b0;
        send_byte(8'h7E, 1'b0);
        send_byte(CMD_TX, 1'b0);
        send_byte(8'h03, 1'b0);
        send_byte(8'hFF, 1'b0);
        send_byte(CMD_RX, 1'b0);
        vectors++;
        if (tx_load_cnt !== 0 || rx_read_cnt !== 0 || spi_tx_data !== 8'h00) begin
            miscompares++;
            $display("FAIL ignore_cmd: tx_load=%0d rx_read=%0d spi_tx_data=%h expected 0 0 00",
                     tx_load_cnt, rx_read_cnt, spi_tx_data);
        end
        cs_high();
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        tx_load_cnt   = 0;
        rx_read_cnt   = 0;
        tx_word_seen  = 10'd0;
        reset         = 1'b1;
        spi_cs        = 1'b1;
        spi_rx_data   = 8'h00;
        spi_rx_strobe = 1'b0;
        rx_active     = 1'b0;
        rx_error      = 1'b0;
        rx_data       = 10'd0;
        rx_empty      = 1'b1;
        tick(1);

        test_reset();
        test_tx();
        test_rx();
        test_rx_empty_pairs();
        test_cs_wins();
        test_tx_abort();
        test_status();
        test_ignore();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/control.md
# control

Command decoder between the SPI slave front end and the coax transmit/receive datapaths. It interprets bytes arriving on the SPI byte interface while chip-select is asserted. It forwards 10-bit coax words to the transmitter. It streams received coax words, with status flags, back to the SPI master while popping the receive FIFO.

## Interface
- No parameters.
- `clk`  input  1  system clock; all logic on rising edge.
- `reset`  input  1  synchronous, active-low reset (asserted when 0).
- `spi_cs`  input  1  SPI chip-select, active-low; high aborts any command.
- `spi_rx_data`  input  8  byte received from SPI master, valid while `spi_rx_strobe`=1.
- `spi_rx_strobe`  input  1  one-cycle pulse per received byte.
- `spi_tx_data`  output  8  byte the SPI slave shifts out on the next transfer.
- `rx_active`  input  1  receiver currently decoding a frame.
- `rx_error`  input  1  receiver error flag.
- `rx_data`  input  10  head word of receive FIFO.
- `rx_empty`  input  1  receive FIFO empty.
- `rx_read`  output  1  one-cycle pop of receive FIFO.
- `tx_data`  output  10  word to transmit, valid with `tx_load`.
- `tx_load`  output  1  one-cycle strobe: push `tx_data` to transmitter.

## Operation
- Commands are the first byte after `spi_cs` falls: 0x04 TX, 0x05 RX, 0x01 STATUS. Any other value → IGNORE.
- States: IDLE, TX_HI, TX_LO, RX_HI, RX_LO, STATUS, IGNORE.
- IDLE: on strobe, decode the command byte.
- TX (0x04) → TX_HI.
  - TX_HI: latch `spi_rx_data[1:0]` as word bits [9:8] → TX_LO.
  - TX_LO: `tx_data` ← {latched[1:0], `spi_rx_data`}, pulse `tx_load` → TX_HI. Pairs repeat until CS rises.
- RX (0x05) → RX_HI; `spi_tx_data` ← high byte = {`rx_empty`, `rx_error`, 4'b0, `rx_data[9:8]`}.
  - RX_HI strobe (byte ignored): `spi_tx_data` ← `rx_data[7:0]` → RX_LO.
  - RX_LO strobe: if `rx_empty`=0, pulse `rx_read`. Then → RX_HI and reload the high byte from the new FIFO head.
  - When the FIFO is empty, the word read back is the current `rx_data` with the empty bit set; no pop.
- STATUS (0x01): `spi_tx_data` ← {5'b0, `rx_empty`, `rx_error`, `rx_active`}, refreshed every cycle; later bytes are ignored.
- IGNORE: all strobes ignored until CS rises.
- `spi_cs`=1 in any state → IDLE next cycle. Partial TX words are discarded; `spi_tx_data` ← 0x00.

## Timing
- Reset values: state IDLE, `spi_tx_data`=0x00, `tx_data`=0, `tx_load`=0, `rx_read`=0.
- `tx_load` is asserted exactly one cycle, the cycle after the second data byte's strobe.
- `rx_read` is asserted exactly one cycle, the cycle after the RX_LO strobe.
- `spi_tx_data` is stable no later than 3 cycles after any strobe. The FIFO head is sampled 2 cycles after `rx_read` to allow pop latency. Strobes are at least 4 cycles apart.
- If a strobe and `spi_cs`=1 occur in the same cycle, CS wins: the byte is dropped.
- If `reset` and a strobe occur in the same cycle, reset wins.
- There is no backpressure on TX; the transmitter must accept every `tx_load`.

## Configuration
- `CONTROL_STATUS_CMD_EN` defined: STATUS command 0x01 is supported as above.
- Undefined: 0x01 decodes as unknown → IGNORE, and `spi_tx_data` stays 0x00.

## Structure
- `control_pkg`: command codes (`CMD_STATUS`=0x01, `CMD_TX`=0x04, `CMD_RX`=0x05), the state enum, and the RX high-byte flag bit positions.
- The block is a single module; no sub-module is required.

## Test plan
- Reset low for 1 cycle → all outputs 0, state IDLE.
- CS low, 0x04, 0x03, 0xFF → `tx_data`=0x3FF with a one-cycle `tx_load`; CS high → IDLE.
- `rx_data`=0x3FF, `rx_empty`=0; CS low, 0x05 → `spi_tx_data`=0x03.
  - Next byte → `spi_tx_data`=0xFF.
  - Next byte → one `rx_read` pulse.
  - Then, with `rx_empty`=1 and `rx_data`=0 → high byte 0x80, low byte 0x00, no `rx_read`.
- 8 further RX byte pairs with the FIFO empty → no `rx_read`; each pair returns 0x80, 0x00.
- TX command, one data byte, then CS high → no `tx_load`. A new TX pair then produces the correct word.
- Command 0x01 with `rx_active`=1, `rx_error`=1 → `spi_tx_data`=0x03 (macro defined). Command 0x7E → no outputs change.
